muldiv_ctrl: RTL
================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the execute stage of the 5-stage MIPS pipeline. It accepts a MULT/MULTU/DIV/DIVU operation from E, holds the pipeline through the hazard unit while it iterates, and then issues a single HI/LO write to the hilo register. It replaces single-cycle HI/LO arithmetic so the E-stage critical path no longer includes a 32×32 divider.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; everything is registered on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `startE`  in  1  a valid mult/div instruction is in E.
- `opE`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcaE`  in  WIDTH  rs operand (multiplicand or dividend), already forwarded.
- `srcbE`  in  WIDTH  rt operand (multiplier or divisor), already forwarded.
- `cancelE`  in  1  abort the in-flight operation (flush or exception).
- `stall_mdE`  out  1  stall request to the hazard unit; OR it into stallF, stallD and the E hold.
- `hilo_we`  out  1  one-cycle write strobe to hilo_reg.
- `hi_o`  out  WIDTH  HI result; valid only while `hilo_we` is high.
- `lo_o`  out  WIDTH  LO result; valid only while `hilo_we` is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `div0`  out  1  high together with `hilo_we` when a divide had a zero divisor.

## Operation
- States: IDLE, MUL, DIV, DONE. Encoding is free.
- IDLE, with `startE`=1 and `cancelE`=0:
  - Latch the operand magnitudes. Signed ops take the absolute value; unsigned ops take the raw value.
  - Latch `neg_q`: signed op and the operand signs differ.
  - Latch `neg_r`: signed divide and the dividend is negative.
  - Clear the counter to 0.
  - Next state is DIV, MUL, or DONE (divisor zero, or a non-iterative multiply).
- DIV: one restoring step per cycle, MSB first.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If there is no borrow, keep the difference and set the quotient LSB.
  - Counter increments; when the counter reaches `WIDTH`-1, go to DONE.
- MUL (iterative build only): shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator. Same counter rule as DIV.
- Sign fix, applied in DONE:
  - product = `neg_q` ? −acc : acc.
  - LO = `neg_q` ? −quo : quo.
  - HI = `neg_r` ? −rem : rem.
- Outputs in DONE:
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero is detected at accept. Go straight to DONE with LO = all ones, HI = `srcaE` as latched (raw), and `div0`=1.
- DONE: `hilo_we`=1 for exactly one cycle, then IDLE. `startE` is ignored in DONE.
- `cancelE`=1 in any state:
  - The next state is IDLE.
  - `hilo_we` and `stall_mdE` are forced to 0 in that same cycle.
  - No HI/LO write ever occurs for the cancelled operation.
- Reset: state IDLE, counter 0. `stall_mdE`, `hilo_we`, `busy` and `div0` are 0; `hi_o` and `lo_o` are 0.

## Timing
- Accept cycle T: `stall_mdE` = `startE` & IDLE & ~`cancelE`. This is combinational, so the instruction is held in E starting at T.
- Stall window:
  - `stall_mdE`=1 in every MUL/DIV cycle (unless cancelled).
  - `stall_mdE`=0 in DONE, so the instruction leaves E at the end of DONE while `hilo_we` fires.
- Iterative divide or multiply: DIV/MUL occupies T+1..T+WIDTH, DONE is T+WIDTH+1, IDLE is T+WIDTH+2.
  - With `WIDTH`=32, that is 33 stall cycles.
- Divide by zero: DONE at T+1, 1 stall cycle.
- Non-iterative multiply: DONE at T+1, 1 stall cycle.
- Back-to-back: a following mult/div can be accepted at T+WIDTH+2 (or T+2 on the short paths). There is no bubble beyond the normal pipeline advance.
- An MFHI/MFLO directly behind the operation sees the new HI/LO, because it is held in D until DONE.
- Reset is sampled every edge and overrides `cancelE` and `startE`.

## Configuration
- `MULDIV_ITER_MUL_EN` defined:
  - Multiply uses the MUL state, `WIDTH` cycles, with timing identical to divide.
  - No hardware multiplier is inferred.
- `MULDIV_ITER_MUL_EN` undefined:
  - The MUL state is removed.
  - The product is formed combinationally from the latched magnitudes and registered into DONE at T+1, giving 1 stall cycle.
  - Divide timing is unchanged.

## Test plan
- DIV 100 / 7, accepted at T → `stall_mdE` high T..T+32; at T+33 `hilo_we`=1, LO=14, HI=2, `div0`=0.
- DIV 0xFFFFFFF9 (−7) / 2 → at T+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234 / 0 → at T+1, `hilo_we`=1, `div0`=1, LO=0xFFFFFFFF, HI=0x1234; stall only at T.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, at T+33 with the macro defined and at T+1 without it.
- MULT 0xFFFFFFFE (−2) × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV started at T, `cancelE` pulsed at T+10 → `stall_mdE`=0 at T+10, IDLE at T+11, no `hilo_we` ever. A separate run with `rst` at T+5 → all outputs 0 at T+6 and a fresh DIVU 9/3 completes correctly with LO=3, HI=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the E stage: stalls the pipeline while iterating,
// then issues one HI/LO write. Define MULDIV_ITER_MUL_EN for a shift-add multiplier instead of a combinational one.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  output logic             stall_mdE,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef MULDIV_ITER_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_div_q, is_div_d;
  logic             div0_q, div0_d;
`ifdef MULDIV_ITER_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mul_sum;
`endif

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [2*WIDTH-1:0] product;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
`ifdef MULDIV_ITER_MUL_EN
      acc_q     <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
`ifdef MULDIV_ITER_MUL_EN
    acc_d     = acc_q;
    mul_sum   = '0;
`endif
    stall_mdE = 1'b0;
    hilo_we   = 1'b0;
    hi_o      = '0;
    lo_o      = '0;
    div0      = 1'b0;
    product   = '0;

    signed_op = ~opE[0];
    a_neg     = signed_op & srcaE[WIDTH-1];
    b_neg     = signed_op & srcbE[WIDTH-1];
    a_mag     = a_neg ? -srcaE : srcaE;
    b_mag     = b_neg ? -srcbE : srcbE;

    // a_q holds the dividend and collects quotient bits as it shifts out MSB first
    rem_sh    = {rem_q, a_q[WIDTH-1]};
    no_borrow = (rem_sh >= {1'b0, b_q});

    case (state_q)
      S_IDLE: begin
        if (startE && !cancelE) begin
          stall_mdE = 1'b1;
          a_d       = a_mag;
          b_d       = b_mag;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = opE[1] & a_neg;
          is_div_d  = opE[1];
          div0_d    = 1'b0;
`ifdef MULDIV_ITER_MUL_EN
          acc_d     = '0;
`endif
          if (opE[1]) begin
            if (srcbE == '0) begin
              div0_d  = 1'b1;
              rem_d   = srcaE;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_ITER_MUL_EN
            state_d = S_MUL;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_DIV: begin
        stall_mdE = 1'b1;
        rem_d     = no_borrow ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        a_d       = {a_q[WIDTH-2:0], no_borrow};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_DONE;
      end
`ifdef MULDIV_ITER_MUL_EN
      S_MUL: begin
        stall_mdE = 1'b1;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
        acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
        b_d       = {1'b0, b_q[WIDTH-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        hilo_we = 1'b1;
        state_d = S_IDLE;
        if (div0_q) begin
          div0 = 1'b1;
          lo_o = '1;
          hi_o = rem_q;
        end else if (is_div_q) begin
          lo_o = neg_quo_q ? -a_q : a_q;
          hi_o = neg_rem_q ? -rem_q : rem_q;
        end else begin
`ifdef MULDIV_ITER_MUL_EN
          product = acc_q;
`else
          product = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif
          if (neg_quo_q) product = -product;
          hi_o = product[2*WIDTH-1:WIDTH];
          lo_o = product[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush kills the operation outright: no stall, no write, back to idle
    if (cancelE) begin
      state_d   = S_IDLE;
      stall_mdE = 1'b0;
      hilo_we   = 1'b0;
      div0      = 1'b0;
      hi_o      = '0;
      lo_o      = '0;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
